// File: rtl/fft4_stream_ctrl.sv
// rtl/fft4_stream_ctrl.sv - streaming 4-point real-input DFT controller (LOAD/CALC/EMIT).
// Define FFT4_STREAM_CTRL_BITREV_EN to emit bins in bit-reversed order 0,2,1,3.
module fft4_stream_ctrl #(
    parameter int DATA_W = 32,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {LOAD, CALC, EMIT} state_t;

    state_t            state;
    logic [1:0]        cnt;
    logic [1:0]        p;
    logic [1:0]        bin;
    logic [DATA_W-1:0] smp    [4];
    logic [DATA_W-1:0] res_re [4];
    logic [DATA_W-1:0] res_im [4];

    logic accept;
    logic xfer;

    assign accept = (state == LOAD) && in_valid;
    assign xfer   = (state == EMIT) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= 2'd0;
            p         <= 2'd0;
            frame_cnt <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    state <= EMIT;
                end
                EMIT: begin
                    if (xfer) begin
                        p <= p + 2'd1;
                        if (p == 2'd3) begin
                            state     <= LOAD;
                            frame_cnt <= frame_cnt + FCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                    cnt   <= 2'd0;
                    p     <= 2'd0;
                end
            endcase
        end
    end

    // Data path carries no reset: results are only exposed in EMIT, after CALC has written them.
    always_ff @(posedge clk) begin
        if (accept) begin
            smp[cnt] <= in_data;
        end
        if (state == CALC) begin
            res_re[0] <= smp[0] + smp[1] + smp[2] + smp[3];
            res_im[0] <= '0;
            res_re[1] <= smp[0] - smp[2];
            res_im[1] <= smp[3] - smp[1];
            res_re[2] <= smp[0] - smp[1] + smp[2] - smp[3];
            res_im[2] <= '0;
            res_re[3] <= smp[0] - smp[2];
            res_im[3] <= smp[1] - smp[3];
        end
    end

`ifdef FFT4_STREAM_CTRL_BITREV_EN
    assign bin = {p[0], p[1]};
`else
    assign bin = p;
`endif

    assign in_ready  = (state == LOAD);
    assign busy      = (state != LOAD);
    assign out_valid = (state == EMIT);
    assign out_re    = out_valid ? res_re[bin] : '0;
    assign out_im    = out_valid ? res_im[bin] : '0;
    assign out_idx   = out_valid ? bin : 2'd0;
    assign out_last  = out_valid && (p == 2'd3);

endmodule

// File: tb/tb_fft4_stream_ctrl.sv
// tb/tb_fft4_stream_ctrl.sv - self-checking bench for fft4_stream_ctrl.
module tb_fft4_stream_ctrl;
    localparam int DW = 32;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic [1:0]    out_idx;
    logic          out_last;
    logic          busy;
    logic [FW-1:0] frame_cnt;

    fft4_stream_ctrl #(.DATA_W(DW), .FCNT_W(FW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } bin_t;

    typedef struct {
        logic [DW-1:0] s  [4];
        logic [DW-1:0] re [4];
        logic [DW-1:0] im [4];
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ord [4];

    logic [DW-1:0] m_smp [$];
    logic [DW-1:0] m_frame [4];
    bit            m_calc;
    bin_t          m_emit [$];
    int            m_fcnt;
    bin_t          cap [$];
    int            rises [$];
    bit            prev_ov;

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bin_t bin_of(input int k, input int pos, input logic [DW-1:0] s [4]);
        bin_t b;
        b.idx  = 2'(k);
        b.last = (pos == 3);
        case (k)
            0:       begin b.re = s[0] + s[1] + s[2] + s[3]; b.im = '0; end
            1:       begin b.re = s[0] - s[2]; b.im = s[3] - s[1]; end
            2:       begin b.re = s[0] - s[1] + s[2] - s[3]; b.im = '0; end
            default: begin b.re = s[0] - s[2]; b.im = s[1] - s[3]; end
        endcase
        return b;
    endfunction

    task automatic model_clear();
        m_smp.delete();
        m_emit.delete();
        m_calc  = 0;
        m_fcnt  = 0;
        prev_ov = 0;
    endtask

    // One clock: compare against the model mid-cycle, then advance the model across the edge.
    task automatic tick();
        logic [79:0] a, e;
        bin_t h;
        bit ev, acc, xfer, was_calc;
        @(negedge clk);
        ev = (m_emit.size() > 0);
        h = '{idx: 2'd0, re: '0, im: '0, last: 1'b0};
        if (ev) h = m_emit[0];
        e = {6'd0, !ev && !m_calc, ev || m_calc, ev, h.last, h.idx, h.re, h.im, FW'(m_fcnt)};
        a = {6'd0, in_ready, busy, out_valid, out_last, out_idx, out_re, out_im, frame_cnt};
        check("cycle_model", a, e);
        if (out_valid && out_ready)
            cap.push_back('{idx: out_idx, re: out_re, im: out_im, last: out_last});
        if (out_valid && !prev_ov) rises.push_back(cyc);
        prev_ov = out_valid;
        acc  = !ev && !m_calc && in_valid;
        xfer = ev && out_ready;
        was_calc = m_calc;
        @(posedge clk);
        if (xfer) begin
            void'(m_emit.pop_front());
            if (m_emit.size() == 0) m_fcnt = (m_fcnt + 1) % (1 << FW);
        end
        if (was_calc) begin
            for (int k = 0; k < 4; k++) m_emit.push_back(bin_of(ord[k], k, m_frame));
            m_calc = 0;
        end
        if (acc) begin
            m_smp.push_back(in_data);
            if (m_smp.size() == 4) begin
                for (int k = 0; k < 4; k++) m_frame[k] = m_smp[k];
                m_smp.delete();
                m_calc = 1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("reset_values",
              {6'd0, in_ready, busy, out_valid, out_last, out_idx, out_re, out_im, frame_cnt},
              {6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        cap.delete();
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1;
            in_data  = v.s[j];
            tick();
        end
        in_valid = 1'b0;
        for (int t = 0; t < 20 && cap.size() < 4; t++) tick();
        check({nm, "_count"}, 80'(cap.size()), 80'd4);
        if (cap.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check({nm, "_idx"},  80'(cap[k].idx),  80'(ord[k]));
                check({nm, "_re"},   80'(cap[k].re),   80'(v.re[ord[k]]));
                check({nm, "_im"},   80'(cap[k].im),   80'(v.im[ord[k]]));
                check({nm, "_last"}, 80'(cap[k].last), 80'(k == 3));
            end
        end
    endtask

    vec_t vt [4];
    int   fc0;

    initial begin
`ifdef FFT4_STREAM_CTRL_BITREV_EN
        ord = '{0, 2, 1, 3};
`else
        ord = '{0, 1, 2, 3};
`endif
        vt[0] = '{s: '{1, 2, 3, 4},
                  re: '{10, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE},
                  im: '{0, 2, 0, 32'hFFFFFFFE}};
        vt[1] = '{s: '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                  re: '{32'hFFFFFFFC, 0, 0, 0}, im: '{0, 0, 0, 0}};
        vt[2] = '{s: '{5, 0, 0, 0}, re: '{5, 5, 5, 5}, im: '{0, 0, 0, 0}};
        vt[3] = '{s: '{32'h10, 32'h20, 32'h30, 32'h40},
                  re: '{32'hA0, 32'hFFFFFFE0, 32'hFFFFFFE0, 32'hFFFFFFE0},
                  im: '{0, 32'h20, 0, 32'hFFFFFFE0}};

        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_clear();
        do_reset();

        for (int i = 0; i < 4; i++) run_vec(vt[i], $sformatf("vec%0d", i));
        check("frame_cnt_after_table", 80'(frame_cnt), 80'd4);

        // Stall at p=1: outputs frozen, inputs ignored.
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1; in_data = vt[0].s[j]; tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            in_valid = 1'b1; in_data = $urandom;
            tick();
            check("stall_idx", 80'(out_idx), 80'(ord[1]));
            check("stall_re", 80'(out_re), 80'(vt[0].re[ord[1]]));
            check("stall_in_ready", 80'(in_ready), 80'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int t = 0; t < 4; t++) tick();

        // Reset mid-load, then mid-emit: partial frames are dropped.
        in_valid = 1'b1; in_data = 7; tick();
        in_data = 9; tick();
        in_valid = 1'b0;
        do_reset();
        run_vec(vt[2], "rst_load");
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1; in_data = 3; tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        do_reset();
        run_vec(vt[0], "rst_emit");

        // Back-to-back frames through the counter wrap.
        do_reset();
        rises.delete();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 17 * 9; t++) begin
            in_data = $urandom;
            tick();
        end
        in_valid = 1'b0;
        check("wrap_frame_cnt", 80'(frame_cnt), 80'd1);
        check("wrap_rises", 80'(rises.size()), 80'd17);
        for (int i = 1; i < rises.size(); i++)
            check("frame_spacing", 80'(rises[i] - rises[i-1]), 80'd9);

        // Random handshakes against the model.
        for (int t = 0; t < 600; t++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            tick();
        end
        fc0 = m_fcnt;
        check("random_frames_seen", 80'(fc0 == 0 && frame_cnt == 0 ? 0 : 1), 80'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fft4_stream_ctrl.md
FFT4_STREAM_CTRL -- requirements
Module: fft4_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the sample and result word width in bits.
REQ-002 SHALL have parameter FCNT_W, default 16, giving the frame counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_W): serial real-sample input stream.
REQ-006 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result stream handshake.
REQ-007 SHALL have ports out_re and out_im (outputs, DATA_W each): real and imaginary parts of the current bin.
REQ-008 SHALL have ports out_idx (output, 2) and out_last (output, 1): bin index of the current bin, and a flag marking the final bin of the frame.
REQ-009 SHALL have ports busy (output, 1) and frame_cnt (output, FCNT_W): high whenever the state is not LOAD, and the count of completed frames.

Function
REQ-010 SHALL implement a three-state FSM: LOAD, CALC, EMIT.
REQ-011 LOAD behaviour:
- in_ready=1.
- Each cycle with in_valid && in_ready stores in_data into slot cnt in the order A, B, C, D, then increments cnt.
- The accept at cnt=3 moves the FSM to CALC and clears cnt.
REQ-012 In CALC, in_ready=0; the FSM SHALL register all eight results in one cycle, then go to EMIT.
REQ-013 Results SHALL be computed modulo 2^DATA_W, unsigned wrap, with no saturation:
- X0 = (A+B+C+D, 0)
- X1 = (A-C, D-B)
- X2 = (A-B+C-D, 0)
- X3 = (A-C, B-D)
REQ-014 EMIT behaviour:
- out_valid=1 and in_ready=0.
- out_re, out_im and out_idx present the bin selected by emit position p (0..3).
- Position p advances only on out_valid && out_ready.
REQ-015 out_last SHALL be 1 exactly when out_valid=1 and p=3.
REQ-016 On the transfer at p=3, the FSM SHALL return to LOAD, clear p and increment frame_cnt, which wraps from 2^FCNT_W-1 to 0.
REQ-017 While out_ready=0 in EMIT, out_re, out_im, out_idx and out_last SHALL hold stable.
REQ-018 Latency: out_valid SHALL first rise in the second cycle after the edge accepting sample D (one CALC cycle between them).
REQ-019 With out_ready held at 1, a frame SHALL take 4 load cycles + 1 CALC cycle + 4 EMIT cycles, giving a sustained throughput of one frame per 9 cycles.
REQ-020 in_valid gaps during LOAD SHALL only stall the load; partially loaded samples are retained.
REQ-021 out_valid SHALL be 0 in LOAD and CALC, and out_re, out_im, out_idx and out_last SHALL be 0 whenever out_valid=0.
REQ-022 in_data SHALL be ignored whenever in_ready=0; no sample is dropped or overwritten.

Reset
REQ-023 While rst=1, regardless of the clock, the block SHALL hold these values:
- state LOAD, cnt=0, p=0
- frame_cnt=0, busy=0, out_valid=0
- out_re=out_im=0, out_idx=0, out_last=0
- in_ready=1
REQ-024 Reset asserted mid-load or mid-emit SHALL discard the partial frame; after deassertion the next accepted sample is treated as A.
REQ-025 Sample and result storage registers need not be reset, but no unreset value SHALL be visible on any output.

Configuration
REQ-026 Macro FFT4_STREAM_CTRL_BITREV_EN SHALL select the EMIT bin order:
- Defined: order 0, 2, 1, 3 (bit-reversed); out_idx still reports the true bin number.
- Undefined: natural order 0, 1, 2, 3.
- All other behaviour is identical in both builds.

Verification
REQ-027 Feed A..D = 1, 2, 3, 4 with out_ready=1 -> bins appear in this order:
- (re, im) = (10, 0), (0xFFFFFFFE, 2), (0xFFFFFFFE, 0), (0xFFFFFFFE, 0xFFFFFFFE)
- out_last set on idx 3; frame_cnt=1.
REQ-028 Feed 0xFFFFFFFF ×4 -> X0.re = 0xFFFFFFFC (wrap); all other parts 0.
REQ-029 Hold out_ready=0 for 5 cycles at p=1 -> outputs stay stable at bin 1, in_ready=0, and sample writes during the stall are ignored.
REQ-030 Pulse rst after 2 samples, then feed 5, 0, 0, 0 -> every bin = (5, 0).
REQ-031 Build with FFT4_STREAM_CTRL_BITREV_EN defined, input 1, 2, 3, 4 -> out_idx sequence 0, 2, 1, 3 with X2 = (0xFFFFFFFE, 0) emitted second.
REQ-032 Run 2^16 + 1 back-to-back frames -> frame_cnt=1, and the spacing between successive first out_valid rises is 9 cycles.
